stopwatch_bcd: RTL and testbench

STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/stopwatch_bcd_if.sv | 46 ++++
 rtl/bcd_digit.sv | 41 ++++
 rtl/stopwatch_bcd.sv | 149 ++++++++++++++
 tb/tb_stopwatch_bcd.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
// Digit widths, digit limits and the control state encoding.
package stopwatch_pkg;

  localparam int BCD_W    = 4;
  localparam int DIG_MAX  = 9;
  localparam int TENS_MAX = 5;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } mmss_t;

endpackage

// File: rtl/stopwatch_bcd_if.sv
// Command and display bundle of the stopwatch.
// master drives commands, slave drives the display.
interface stopwatch_bcd_if;
  import stopwatch_pkg::*;

  logic tick_in;
  logic start_stop;
  logic lap;
  logic clear;
  bcd_t sec_ones;
  bcd_t sec_tens;
  bcd_t min_ones;
  bcd_t min_tens;
  logic running;
  logic lap_hold;
  logic rollover;

  modport master (
    output tick_in,
    output start_stop,
    output lap,
    output clear,
    input  sec_ones,
    input  sec_tens,
    input  min_ones,
    input  min_tens,
    input  running,
    input  lap_hold,
    input  rollover
  );

  modport slave (
    input  tick_in,
    input  start_stop,
    input  lap,
    input  clear,
    output sec_ones,
    output sec_tens,
    output min_ones,
    output min_tens,
    output running,
    output lap_hold,
    output rollover
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD counter digit, wraps at LIMIT.
// carry is high when inc arrives with the digit at LIMIT.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int LIMIT = DIG_MAX
) (
  input  logic clk,
  input  logic ar,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  bcd_t q_q;
  bcd_t q_d;
  logic at_lim;

  always_comb begin
    at_lim = (q_q == bcd_t'(LIMIT));
    carry  = inc & at_lim;
    q_d    = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = at_lim ? '0 : q_q + bcd_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ar) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/stopwatch_bcd.sv
// mm:ss BCD stopwatch with run/pause/lap control.
// tick_in is a divided clock sampled as data in the clk domain.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN_TENS = TENS_MAX,
  parameter bit TICK_ACTIVE  = 1'b1
) (
  input  logic clk,
  input  logic ar,
  input  logic tick_in,
  input  logic start_stop,
  input  logic lap,
  input  logic clear,
  output bcd_t sec_ones,
  output bcd_t sec_tens,
  output bcd_t min_ones,
  output bcd_t min_tens,
  output logic running,
  output logic lap_hold,
  output logic rollover
);

  state_e state_q;
  state_e state_d;
  logic   tick_q;
  logic   tick_d;
  logic   tick;
  mmss_t  lap_q;
  mmss_t  lap_d;
  mmss_t  live;
  mmss_t  disp;
  logic   rollover_q;
  logic   rollover_d;
  logic   counting;
  logic   inc;
  logic   c_so;
  logic   c_st;
  logic   c_mo;
  logic   c_mt;

  always_comb begin
    tick_d = tick_in;
    if (TICK_ACTIVE) begin
      tick = tick_in & ~tick_q;
    end else begin
      tick = ~tick_in & tick_q;
    end
  end

  // a tick that lands with clear is dropped
  always_comb begin
    counting = (state_q == RUN) |
               (state_q == LAP);
    inc      = tick & counting & ~clear;
  end

  bcd_digit #(.LIMIT(DIG_MAX)) u_sec_ones (
    .clk   (clk),
    .ar    (ar),
    .clr   (clear),
    .inc   (inc),
    .q     (live.sec_ones),
    .carry (c_so)
  );

  bcd_digit #(.LIMIT(TENS_MAX)) u_sec_tens (
    .clk   (clk),
    .ar    (ar),
    .clr   (clear),
    .inc   (c_so),
    .q     (live.sec_tens),
    .carry (c_st)
  );

  bcd_digit #(.LIMIT(DIG_MAX)) u_min_ones (
    .clk   (clk),
    .ar    (ar),
    .clr   (clear),
    .inc   (c_st),
    .q     (live.min_ones),
    .carry (c_mo)
  );

  bcd_digit #(.LIMIT(MAX_MIN_TENS)) u_min_tens (
    .clk   (clk),
    .ar    (ar),
    .clr   (clear),
    .inc   (c_mo),
    .q     (live.min_tens),
    .carry (c_mt)
  );

  always_comb begin
    rollover_d = c_mt;
  end

  // priority order: clear, then start_stop, then lap
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    priority case (1'b1)
      clear: begin
        state_d = IDLE;
        lap_d   = '0;
      end
      start_stop: begin
        state_d = counting ? PAUSE : RUN;
      end
      lap: begin
        if (state_q == RUN) begin
          state_d = LAP;
          lap_d   = live;
        end else if (state_q == LAP) begin
          state_d = RUN;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (ar) begin
      state_q    <= IDLE;
      tick_q     <= 1'b0;
      lap_q      <= '0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      lap_q      <= lap_d;
      rollover_q <= rollover_d;
    end
  end

  always_comb begin
    disp = (state_q == LAP) ? lap_q : live;
  end

  assign sec_ones = disp.sec_ones;
  assign sec_tens = disp.sec_tens;
  assign min_ones = disp.min_ones;
  assign min_tens = disp.min_tens;
  assign running  = counting;
  assign lap_hold = (state_q == LAP);
  assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd.
// Expected digits are hand-written BCD mm:ss constants.
module tb_stopwatch_bcd;

  logic clk = 1'b0;
  logic ar  = 1'b1;

  always #5 clk = ~clk;

  stopwatch_bcd_if sw ();

  stopwatch_bcd #(
    .MAX_MIN_TENS (5),
    .TICK_ACTIVE  (1'b1)
  ) dut (
    .clk        (clk),
    .ar         (ar),
    .tick_in    (sw.tick_in),
    .start_stop (sw.start_stop),
    .lap        (sw.lap),
    .clear      (sw.clear),
    .sec_ones   (sw.sec_ones),
    .sec_tens   (sw.sec_tens),
    .min_ones   (sw.min_ones),
    .min_tens   (sw.min_tens),
    .running    (sw.running),
    .lap_hold   (sw.lap_hold),
    .rollover   (sw.rollover)
  );

  int errs   = 0;
  int checks = 0;
  int roll_seen = 0;
  int r0;

  logic [15:0] disp;
  assign disp = {sw.min_tens, sw.min_ones,
                 sw.sec_tens, sw.sec_ones};

  always @(negedge clk) begin
    if (sw.rollover === 1'b1) roll_seen++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick1();
    sw.tick_in = 1'b1;
    cyc(1);
    sw.tick_in = 1'b0;
    cyc(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick1();
  endtask

  task automatic pulse_ss();
    sw.start_stop = 1'b1;
    cyc(1);
    sw.start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    sw.lap = 1'b1;
    cyc(1);
    sw.lap = 1'b0;
  endtask

  task automatic pulse_clr();
    sw.clear = 1'b1;
    cyc(1);
    sw.clear = 1'b0;
  endtask

  initial begin
    sw.tick_in    = 1'b0;
    sw.start_stop = 1'b0;
    sw.lap        = 1'b0;
    sw.clear      = 1'b0;

    // reset, then idle ticks
    cyc(2);
    chk("rst_disp", 32'(disp), 32'h0000);
    chk("rst_run", 32'(sw.running), 0);
    chk("rst_lap", 32'(sw.lap_hold), 0);
    chk("rst_roll", 32'(sw.rollover), 0);
    ar = 1'b0;
    ticks(5);
    chk("idle_disp", 32'(disp), 32'h0000);
    chk("idle_run", 32'(sw.running), 0);
    chk("idle_roll", 32'(roll_seen), 0);

    // run and latency
    pulse_ss();
    chk("run_on", 32'(sw.running), 1);
    ticks(2);
    chk("run_2", 32'(disp), 32'h0002);
    sw.tick_in = 1'b1;
    cyc(1);
    chk("lat_3", 32'(disp), 32'h0003);
    cyc(10);
    chk("hold_hi", 32'(disp), 32'h0003);
    sw.tick_in = 1'b0;
    cyc(1);

    // full-scale wrap
    ticks(3595);
    chk("pre_5958", 32'(disp), 32'h5958);
    tick1();
    chk("full", 32'(disp), 32'h5959);
    r0 = roll_seen;
    sw.tick_in = 1'b1;
    cyc(1);
    chk("wrap", 32'(disp), 32'h0000);
    chk("wrap_roll", 32'(sw.rollover), 1);
    chk("wrap_run", 32'(sw.running), 1);
    sw.tick_in = 1'b0;
    cyc(1);
    chk("roll_off", 32'(sw.rollover), 0);
    cyc(2);
    chk("roll_once", 32'(roll_seen - r0), 1);

    // lap hold and release
    ticks(7);
    chk("pre_lap", 32'(disp), 32'h0007);
    pulse_lap();
    chk("lap_on", 32'(sw.lap_hold), 1);
    chk("lap_run", 32'(sw.running), 1);
    ticks(4);
    chk("lap_freeze", 32'(disp), 32'h0007);
    pulse_lap();
    chk("lap_rel", 32'(disp), 32'h0011);
    chk("lap_off", 32'(sw.lap_hold), 0);

    // clear + start_stop + tick together
    tick1();
    chk("at_12", 32'(disp), 32'h0012);
    sw.clear      = 1'b1;
    sw.start_stop = 1'b1;
    sw.tick_in    = 1'b1;
    cyc(1);
    sw.clear      = 1'b0;
    sw.start_stop = 1'b0;
    sw.tick_in    = 1'b0;
    chk("clr_disp", 32'(disp), 32'h0000);
    chk("clr_run", 32'(sw.running), 0);
    cyc(1);
    chk("clr_tick", 32'(disp), 32'h0000);

    // start_stop + tick in RUN
    pulse_ss();
    ticks(4);
    chk("at_04", 32'(disp), 32'h0004);
    sw.start_stop = 1'b1;
    sw.tick_in    = 1'b1;
    cyc(1);
    sw.start_stop = 1'b0;
    sw.tick_in    = 1'b0;
    chk("ss_tick", 32'(disp), 32'h0005);
    chk("pause_run", 32'(sw.running), 0);
    cyc(1);
    tick1();
    chk("pause_hold", 32'(disp), 32'h0005);
    pulse_lap();
    chk("pause_lap", 32'(sw.lap_hold), 0);
    pulse_ss();
    chk("resume", 32'(sw.running), 1);
    tick1();
    chk("resume_06", 32'(disp), 32'h0006);

    // reset mid-run in LAP
    pulse_clr();
    chk("clr2", 32'(disp), 32'h0000);
    pulse_ss();
    ticks(207);
    chk("at_0327", 32'(disp), 32'h0327);
    pulse_lap();
    chk("lap2_on", 32'(sw.lap_hold), 1);
    r0 = roll_seen;
    ar         = 1'b1;
    sw.tick_in = 1'b1;
    sw.lap     = 1'b1;
    cyc(1);
    ar         = 1'b0;
    sw.lap     = 1'b0;
    chk("ar_disp", 32'(disp), 32'h0000);
    chk("ar_lap", 32'(sw.lap_hold), 0);
    chk("ar_run", 32'(sw.running), 0);
    chk("ar_roll", 32'(sw.rollover), 0);
    cyc(2);
    sw.tick_in = 1'b0;
    cyc(1);
    chk("ar_idle", 32'(disp), 32'h0000);
    chk("ar_noroll", 32'(roll_seen - r0), 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
